// File: rtl/fft_frame_packer.sv
// fft_frame_packer: turns 8-bit offset-binary audio samples into 16-bit signed
// complex words, buffers them in a small FIFO and streams them to the FFT core
// as AXI-Stream frames of FRAME_LEN beats, with tlast on the final beat.
// Optional feature macro: HANN_WINDOW_EN scales each real sample by a window
// coefficient from a ROM initialised with a Hann window.
`default_nettype none

module fft_frame_packer #(
    parameter int FRAME_LEN  = 1024,
    parameter int FIFO_DEPTH = 16
`ifdef HANN_WINDOW_EN
    ,
    parameter string WINDOW_FILE = "hann_1024.mem"
`endif
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          audio_valid_in,
    input  logic [7:0]                    audio_in,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_out,
    output logic                          overflow_out,
    output logic [15:0]                   frame_count_out
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;
    localparam int IDX_W = $clog2(FRAME_LEN);

    logic [15:0]        fifo_mem_q [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [IDX_W-1:0]   next_idx_q, next_idx_d;
    logic [31:0]        tdata_q, tdata_d;
    logic               tvalid_q, tvalid_d;
    logic               tlast_q, tlast_d;
    logic               overflow_q, overflow_d;
    logic [15:0]        frame_count_q, frame_count_d;

    logic               full, empty, pop, push, drop, handshake;
    logic [15:0]        sample_real;
    logic signed [15:0] head_real;
    logic signed [15:0] load_real;

    // Offset-binary to left-justified two's complement, and the word at the FIFO head.
    always_comb begin
        sample_real = {~audio_in[7], audio_in[6:0], 8'h00};
        head_real   = fifo_mem_q[rd_ptr_q];
    end

`ifdef HANN_WINDOW_EN
    logic [15:0]        window_rom [FRAME_LEN];
    logic [15:0]        coef_q;
    logic [IDX_W-1:0]   rom_addr_d;
    logic signed [32:0] windowed;

    // Window ROM contents: Hann window in unsigned Q0.16, computed at elaboration start.
    initial begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            real w;
            w = 0.5 - 0.5 * $cos(2.0 * 3.14159265358979 * real'(i) / real'(FRAME_LEN));
            window_rom[i] = 16'($rtoi(w * 65535.0 + 0.5));
        end
    end

    // Read address looks one load ahead so the coefficient is waiting when the word is loaded.
    always_comb begin
        rom_addr_d = rst_in ? '0 : next_idx_d;
    end

    // Synchronous window ROM read.
    always_ff @(posedge clk_in) begin
        coef_q <= window_rom[rom_addr_d];
    end

    // Signed sample times unsigned Q0.16 coefficient; dropping 16 LSBs floors toward -inf.
    always_comb begin
        windowed  = $signed(head_real) * $signed({1'b0, coef_q});
        load_real = windowed[31:16];
    end
`else
    // Without the window the FIFO word goes to the output unscaled.
    always_comb begin
        load_real = head_real;
    end
`endif

    // Handshake, FIFO control and next-state for every registered output.
    always_comb begin
        full      = (level_q == LVL_W'(FIFO_DEPTH));
        empty     = (level_q == '0);
        handshake = tvalid_q && m_axis_tready;
        pop       = !empty && (!tvalid_q || m_axis_tready);
        push      = audio_valid_in && (!full || pop);
        drop      = audio_valid_in && full && !pop;

        wr_ptr_d      = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d       = level_q;
        tdata_d       = tdata_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        next_idx_d    = next_idx_q;
        overflow_d    = overflow_q | drop;
        frame_count_d = frame_count_q;

        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        if (pop) begin
            tvalid_d   = 1'b1;
            tdata_d    = {16'h0000, load_real};
            tlast_d    = (next_idx_q == IDX_W'(FRAME_LEN - 1));
            next_idx_d = next_idx_q + IDX_W'(1);
        end else if (handshake) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end

        if (handshake && tlast_q) begin
            frame_count_d = frame_count_q + 16'd1;
        end
    end

    // Control and output registers; reset discards any partial frame.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            next_idx_q    <= '0;
            tdata_q       <= '0;
            tvalid_q      <= 1'b0;
            tlast_q       <= 1'b0;
            overflow_q    <= 1'b0;
            frame_count_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            next_idx_q    <= next_idx_d;
            tdata_q       <= tdata_d;
            tvalid_q      <= tvalid_d;
            tlast_q       <= tlast_d;
            overflow_q    <= overflow_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Sample storage; contents need no reset because occupancy is tracked separately.
    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= sample_real;
        end
    end

    assign m_axis_tdata    = tdata_q;
    assign m_axis_tvalid   = tvalid_q;
    assign m_axis_tlast    = tlast_q;
    assign fifo_level_out  = level_q;
    assign overflow_out    = overflow_q;
    assign frame_count_out = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_packer.sv
// Testbench for fft_frame_packer (default build, FRAME_LEN=8, FIFO_DEPTH=16).
// A queue-level model of "samples held in the FIFO plus one output register"
// is checked against the DUT every cycle; directed literals pin the model.
`default_nettype none

module tb_fft_frame_packer;

    localparam int FRAME_LEN  = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic               clk_in         = 1'b0;
    logic               rst_in         = 1'b1;
    logic               audio_valid_in = 1'b0;
    logic [7:0]         audio_in       = 8'h00;
    logic               m_axis_tready  = 1'b0;
    logic [31:0]        m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tlast;
    logic [LVL_W-1:0]   fifo_level_out;
    logic               overflow_out;
    logic [15:0]        frame_count_out;

    int  nChecks = 0;
    int  nFail   = 0;
    bit  started = 1'b0;

    // Model state: samples waiting in the FIFO, the beat sitting in the output register.
    logic [31:0] mFifo [$];
    bit          mRegValid  = 1'b0;
    logic [31:0] mRegData   = '0;
    bit          mRegLast   = 1'b0;
    int          mLoaded    = 0;
    logic [15:0] mFrames    = '0;
    bit          mOverflow  = 1'b0;

    // Every beat the DUT hands over, as {tlast, tdata}.
    logic [32:0] delivered [$];

    fft_frame_packer #(
        .FRAME_LEN  (FRAME_LEN),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .audio_valid_in  (audio_valid_in),
        .audio_in        (audio_in),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tlast    (m_axis_tlast),
        .m_axis_tready   (m_axis_tready),
        .fifo_level_out  (fifo_level_out),
        .overflow_out    (overflow_out),
        .frame_count_out (frame_count_out)
    );

    always #5 clk_in = ~clk_in;

    // Arithmetic form of the conversion: centre on 128, scale by 256, imag zero.
    function automatic logic [31:0] expWord(input logic [7:0] a);
        int r;
        r = (int'(a) - 128) * 256;
        return {16'h0000, 16'(r)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic rdy);
        @(posedge clk_in);
        #1;
        audio_valid_in = v;
        audio_in       = d;
        m_axis_tready  = rdy;
    endtask

    task automatic doReset();
        @(posedge clk_in);
        #1;
        rst_in         = 1'b1;
        audio_valid_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
    endtask

    // Model update: the output register drains on a handshake and refills from the
    // FIFO head; an incoming sample is kept only if the FIFO has room after that.
    always @(posedge clk_in) begin
        if (rst_in) begin
            mFifo.delete();
            mRegValid = 1'b0;
            mRegData  = '0;
            mRegLast  = 1'b0;
            mLoaded   = 0;
            mFrames   = '0;
            mOverflow = 1'b0;
        end else begin
            bit hs;
            bit refill;
            hs     = mRegValid && m_axis_tready;
            refill = (mFifo.size() > 0) && (!mRegValid || m_axis_tready);
            if (hs && mRegLast) mFrames = mFrames + 16'd1;
            if (hs) begin
                mRegValid = 1'b0;
                mRegLast  = 1'b0;
            end
            if (refill) begin
                mRegData  = mFifo.pop_front();
                mRegValid = 1'b1;
                mRegLast  = ((mLoaded % FRAME_LEN) == FRAME_LEN - 1);
                mLoaded++;
            end
            if (audio_valid_in) begin
                if (mFifo.size() < FIFO_DEPTH) mFifo.push_back(expWord(audio_in));
                else mOverflow = 1'b1;
            end
        end
    end

    // Per-cycle comparison of all outputs against the model, mid-cycle.
    always @(negedge clk_in) begin
        if (started) begin
            checkOutput("tvalid", 32'(m_axis_tvalid), 32'(mRegValid));
            if (mRegValid) begin
                checkOutput("tdata", m_axis_tdata, mRegData);
                checkOutput("tlast", 32'(m_axis_tlast), 32'(mRegLast));
            end
            checkOutput("fifo_level", 32'(fifo_level_out), 32'(mFifo.size()));
            checkOutput("overflow", 32'(overflow_out), 32'(mOverflow));
            checkOutput("frame_count", 32'(frame_count_out), 32'(mFrames));
        end
    end

    // Record each beat that will complete at the coming rising edge.
    always @(negedge clk_in) begin
        if (!rst_in && m_axis_tvalid && m_axis_tready) begin
            delivered.push_back({m_axis_tlast, m_axis_tdata});
        end
    end

    initial begin
        // Reset held two cycles: every output reads zero, and stays idle without audio.
        @(posedge clk_in);
        started = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("rst_tdata", m_axis_tdata, 32'd0);
        checkOutput("rst_level", 32'(fifo_level_out), 32'd0);
        checkOutput("rst_overflow", 32'(overflow_out), 32'd0);
        checkOutput("rst_frames", 32'(frame_count_out), 32'd0);
        #1;
        rst_in = 1'b0;
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk_in);
        checkOutput("idle_tvalid", 32'(m_axis_tvalid), 32'd0);

        // Conversion of midscale, full scale and zero codes.
        delivered.delete();
        applyStimulus(1'b1, 8'h80, 1'b1);
        applyStimulus(1'b1, 8'hFF, 1'b1);
        applyStimulus(1'b1, 8'h00, 1'b1);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("conv_count", 32'(delivered.size()), 32'd3);
        if (delivered.size() == 3) begin
            checkOutput("conv_0x80", delivered[0][31:0], 32'h0000_0000);
            checkOutput("conv_0xFF", delivered[1][31:0], 32'h0000_7F00);
            checkOutput("conv_0x00", delivered[2][31:0], 32'h0000_8000);
        end

        // Latency: written in cycle t, valid in cycle t+2 and not before.
        applyStimulus(1'b1, 8'hC0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1);
        @(negedge clk_in);
        checkOutput("lat_t1_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(negedge clk_in);
        checkOutput("lat_t2_tvalid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("lat_t2_tdata", m_axis_tdata, 32'h0000_4000);

        // Framing: 24 ramp samples make three frames.
        doReset();
        delivered.delete();
        for (int i = 0; i < 24; i++) applyStimulus(1'b1, 8'(i * 8), 1'b1);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("frame_beats", 32'(delivered.size()), 32'd24);
        if (delivered.size() == 24) begin
            for (int i = 0; i < 24; i++) begin
                checkOutput($sformatf("frame_tlast_%0d", i), 32'(delivered[i][32]),
                            32'((i == 7) || (i == 15) || (i == 23)));
            end
            checkOutput("frame_beat1", delivered[1][31:0], 32'h0000_8800);
        end
        @(negedge clk_in);
        checkOutput("frame_count3", 32'(frame_count_out), 32'd3);

        // Backpressure: 20 samples against a stalled sink; 17 kept, 3 dropped.
        doReset();
        delivered.delete();
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        @(negedge clk_in);
        checkOutput("bp_level", 32'(fifo_level_out), 32'd16);
        checkOutput("bp_overflow", 32'(overflow_out), 32'd1);
        checkOutput("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
        checkOutput("bp_tdata", m_axis_tdata, 32'h0000_9000);
        repeat (25) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("bp_count", 32'(delivered.size()), 32'd17);
        if (delivered.size() == 17) begin
            checkOutput("bp_first", delivered[0][31:0], 32'h0000_9000);
            checkOutput("bp_last", delivered[16][31:0], 32'h0000_A000);
            checkOutput("bp_tlast7", 32'(delivered[7][32]), 32'd1);
        end
        @(negedge clk_in);
        checkOutput("bp_sticky", 32'(overflow_out), 32'd1);

        // Reset in the middle of a frame: the next frame starts fresh at beat 0.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h40 + i), 1'b1);
        doReset();
        delivered.delete();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1);
        repeat (5) applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("mid_count", 32'(delivered.size()), 32'd10);
        if (delivered.size() == 10) begin
            checkOutput("mid_first", delivered[0][31:0], 32'h0000_4000);
            checkOutput("mid_tlast6", 32'(delivered[6][32]), 32'd0);
            checkOutput("mid_tlast7", 32'(delivered[7][32]), 32'd1);
        end
        @(negedge clk_in);
        checkOutput("mid_frames", 32'(frame_count_out), 32'd1);
        checkOutput("mid_overflow", 32'(overflow_out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

`default_nettype wire
